// File: rtl/prf_int_wb_arbiter_pkg.sv
// Shared definitions for the integer PRF writeback arbiter.
// Default sizes match the integer PRF configuration (two write ways, 128 registers).
package prf_int_wb_arbiter_pkg;

    localparam int WB_INT_NUM_REQ     = 4;
    localparam int PRF_INT_WAYS       = 2;
    localparam int PRF_INT_INDEX_SIZE = 7;
    localparam int WB_DATA_W          = 32;

    typedef enum logic [1:0] {
        WB_ALU0 = 2'd0,
        WB_ALU1 = 2'd1,
        WB_MDU  = 2'd2,
        WB_LSU  = 2'd3
    } wb_req_id_e;

    // A single requester still needs a one-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prf_int_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: grants up to NUM_PORTS held slots starting at rr_ptr.
// Zero-index slots are granted (to drain them) but take no write port.
module prf_int_wb_arbiter_rr_pick
    import prf_int_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = WB_INT_NUM_REQ,
    parameter int NUM_PORTS = PRF_INT_WAYS,
    parameter int PTR_W     = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                hold_valid,
    input  logic [NUM_REQ-1:0]                zero_mask,
    input  logic [PTR_W-1:0]                  rr_ptr,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_PORTS-1:0]              port_valid,
    output logic [NUM_PORTS-1:0][PTR_W-1:0]   port_sel,
    output logic [PTR_W-1:0]                  next_ptr
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] slot;
    logic             placed;

    always_comb begin
        grant      = '0;
        port_valid = '0;
        port_sel   = '0;
        next_ptr   = rr_ptr;
        sum        = '0;
        slot       = '0;
        placed     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            slot = sum[PTR_W-1:0];
            // Scanning stops once every port is taken, so a zero-index slot
            // further on cannot drag rr_ptr past an ungranted valid slot.
            if (hold_valid[slot] && !(&port_valid)) begin
                grant[slot] = 1'b1;
                next_ptr    = (slot == PTR_W'(NUM_REQ - 1)) ? '0 : slot + PTR_W'(1);
                if (!zero_mask[slot]) begin
                    placed = 1'b0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (!placed && !port_valid[p]) begin
                            port_valid[p] = 1'b1;
                            port_sel[p]   = slot;
                            placed        = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/prf_int_wb_arbiter.sv
// Integer PRF writeback arbiter: one holding slot per requester, round-robin grant
// onto NUM_PORTS registered PRF write ports.
module prf_int_wb_arbiter
    import prf_int_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = WB_INT_NUM_REQ,
    parameter int NUM_PORTS = PRF_INT_WAYS,
    parameter int IDX_W     = PRF_INT_INDEX_SIZE
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]     req_index,
    input  logic [NUM_REQ-1:0][31:0]          req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_PORTS-1:0]              rd_en,
    output logic [NUM_PORTS-1:0][IDX_W-1:0]   rd_index,
    output logic [NUM_PORTS-1:0][31:0]        rd_data
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [NUM_REQ-1:0]              hold_valid;
    logic [NUM_REQ-1:0][IDX_W-1:0]   hold_index;
    logic [NUM_REQ-1:0][31:0]        hold_data;
    logic [NUM_REQ-1:0]              zero_mask;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              xfer;
    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                next_ptr;
    logic [NUM_PORTS-1:0]            port_valid;
    logic [NUM_PORTS-1:0][PTR_W-1:0] port_sel;

    always_comb begin
        zero_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            zero_mask[i] = (hold_index[i] == '0);
        end
    end

    // Grant depends only on registered slot state, so ready never sees req_valid.
    assign req_ready = ~hold_valid | grant;
    assign xfer      = req_valid & req_ready;

    prf_int_wb_arbiter_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .hold_valid (hold_valid),
        .zero_mask  (zero_mask),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .port_valid (port_valid),
        .port_sel   (port_sel),
        .next_ptr   (next_ptr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid <= '0;
            hold_index <= '0;
            hold_data  <= '0;
            rr_ptr     <= '0;
            rd_en      <= '0;
            rd_index   <= '0;
            rd_data    <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_index[i] <= req_index[i];
                    hold_data[i]  <= req_data[i];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            rr_ptr <= next_ptr;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_en[p] <= port_valid[p];
                if (port_valid[p]) begin
                    rd_index[p] <= hold_index[port_sel[p]];
                    rd_data[p]  <= hold_data[port_sel[p]];
                end else begin
                    rd_index[p] <= '0;
                    rd_data[p]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_prf_int_wb_arbiter.sv
// Self-checking bench for prf_int_wb_arbiter (NUM_REQ=4, NUM_PORTS=2).
// Tests push expected PRF writes into a queue; a negedge monitor pops and compares them.
module tb_prf_int_wb_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int NUM_PORTS = 2;
    localparam int IDX_W     = 7;

    logic                                clock = 1'b0;
    logic                                reset = 1'b1;
    logic [NUM_REQ-1:0]                  req_valid = '0;
    logic [NUM_REQ-1:0][IDX_W-1:0]       req_index = '0;
    logic [NUM_REQ-1:0][31:0]            req_data  = '0;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_PORTS-1:0]                rd_en;
    logic [NUM_PORTS-1:0][IDX_W-1:0]     rd_index;
    logic [NUM_PORTS-1:0][31:0]          rd_data;

    typedef struct {
        int                              due;
        logic [NUM_PORTS-1:0]            en;
        logic [NUM_PORTS-1:0][IDX_W-1:0] idx;
        logic [NUM_PORTS-1:0][31:0]      dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;
    bit   mon_on = 1'b0;

    prf_int_wb_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_index (req_index),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rd_en     (rd_en),
        .rd_index  (rd_index),
        .rd_data   (rd_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every cycle either matches the queued write or expects silence.
    always @(negedge clock) begin
        if (mon_on) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                mon_e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_write: due cycle %0d never checked (now %0d)", mon_e.due, cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                tests++;
                if (rd_en !== mon_e.en || rd_index !== mon_e.idx || rd_data !== mon_e.dat) begin
                    fails++;
                    $display("FAIL write_port cyc %0d: got en=%b idx=%h data=%h, want en=%b idx=%h data=%h",
                             cyc, rd_en, rd_index, rd_data, mon_e.en, mon_e.idx, mon_e.dat);
                end
            end else begin
                tests++;
                if (rd_en !== '0 || rd_index !== '0 || rd_data !== '0) begin
                    fails++;
                    $display("FAIL idle_port cyc %0d: got en=%b idx=%h data=%h, want all zero",
                             cyc, rd_en, rd_index, rd_data);
                end
            end
            if (rd_en === 2'b11 && rd_index[0] === rd_index[1]) begin
                fails++;
                $display("FAIL dup_index cyc %0d: both ports write index %0d", cyc, rd_index[0]);
            end
        end
    end

    function automatic exp_t mk_exp(input int due, input logic [1:0] en,
                                    input logic [IDX_W-1:0] i0, input logic [31:0] d0,
                                    input logic [IDX_W-1:0] i1, input logic [31:0] d1);
        exp_t e;
        e.due    = due;
        e.en     = en;
        e.idx[0] = i0;
        e.dat[0] = d0;
        e.idx[1] = i1;
        e.dat[1] = d1;
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            req_valid = '0;
        end
    endtask

    task automatic apply_reset();
        next_cycle();
        reset     = 1'b1;
        req_valid = '0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (rd_en !== 2'b00) begin fails++; $display("FAIL reset_rd_en: got %b want 00", rd_en); end
        tests++;
        if (rd_index !== '0) begin fails++; $display("FAIL reset_rd_index: got %h want 0", rd_index); end
        tests++;
        if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        tests++;
        if (req_ready !== 4'b1111) begin fails++; $display("FAIL reset_ready: got %b want 1111", req_ready); end
        tests++;
        if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
        mon_on = 1'b1;
    endtask

    task automatic test_single_write();
        next_cycle();
        req_valid    = 4'b0001;
        req_index[0] = 7'd5;
        req_data[0]  = 32'h0000_DEAD;
        exp_q.push_back(mk_exp(cyc + 2, 2'b01, 7'd5, 32'h0000_DEAD, '0, '0));
        @(negedge clock);
        tests++;
        if (req_ready !== 4'b1111) begin fails++; $display("FAIL single_ready: got %b want 1111", req_ready); end
        idle(2);
        @(negedge clock);
        tests++;
        if (dut.rr_ptr !== 2'd1) begin fails++; $display("FAIL single_rr_ptr: got %0d want 1", dut.rr_ptr); end
        idle(3);
    endtask

    task automatic test_contention();
        logic [3:0]  pend_v;
        logic [31:0] pend_d[4];
        logic [31:0] off_d[4];
        logic [3:0]  gmask;
        logic [3:0]  exp_rdy;
        logic [1:0]  en;
        logic [IDX_W-1:0] ei[2];
        logic [31:0] ed[2];
        int          np;
        int          n_active = 6;
        apply_reset();
        pend_v = '0;
        for (int i = 0; i < 4; i++) begin
            off_d[i]  = 32'hC000_0000 + 32'(i);
            pend_d[i] = '0;
        end
        for (int k = 0; k < n_active + 3; k++) begin
            next_cycle();
            req_valid = (k < n_active) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                req_index[i] = 7'(10 + i);
                req_data[i]  = off_d[i];
            end
            gmask = '0;
            if (k > 0) gmask = (k % 2 == 1) ? 4'b0011 : 4'b1100;
            gmask   = gmask & pend_v;
            exp_rdy = ~pend_v | gmask;
            if (gmask != '0) begin
                en = '0; np = 0;
                ei[0] = '0; ei[1] = '0; ed[0] = '0; ed[1] = '0;
                for (int i = 0; i < 4; i++) begin
                    if (gmask[i] && np < 2) begin
                        en[np] = 1'b1;
                        ei[np] = 7'(10 + i);
                        ed[np] = pend_d[i];
                        np++;
                    end
                end
                exp_q.push_back(mk_exp(cyc + 1, en, ei[0], ed[0], ei[1], ed[1]));
            end
            @(negedge clock);
            if (k < n_active) begin
                tests++;
                if (req_ready !== exp_rdy) begin
                    fails++;
                    $display("FAIL contention_ready k=%0d: got %b want %b", k, req_ready, exp_rdy);
                end
            end
            pend_v = pend_v & ~gmask;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && exp_rdy[i]) begin
                    pend_v[i] = 1'b1;
                    pend_d[i] = off_d[i];
                    off_d[i]  = off_d[i] + 32'h10;
                end
            end
        end
        idle(3);
    endtask

    task automatic test_zero_index();
        apply_reset();
        next_cycle();
        req_valid    = 4'b0011;
        req_index[0] = 7'd20;  req_data[0] = 32'h2000_0000;
        req_index[1] = 7'd21;  req_data[1] = 32'h2100_0000;
        exp_q.push_back(mk_exp(cyc + 2, 2'b11, 7'd20, 32'h2000_0000, 7'd21, 32'h2100_0000));
        next_cycle();
        req_valid    = 4'b1100;
        req_index[2] = 7'd0;   req_data[2] = 32'h0BAD_0000;
        req_index[3] = 7'd7;   req_data[3] = 32'h0000_0777;
        next_cycle();
        req_valid = '0;
        exp_q.push_back(mk_exp(cyc + 1, 2'b01, 7'd7, 32'h0000_0777, '0, '0));
        @(negedge clock);
        tests++;
        if (dut.rr_ptr !== 2'd2) begin fails++; $display("FAIL zero_rr_before: got %0d want 2", dut.rr_ptr); end
        tests++;
        if (req_ready !== 4'b1111) begin fails++; $display("FAIL zero_ready_grant: got %b want 1111", req_ready); end
        next_cycle();
        @(negedge clock);
        tests++;
        if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL zero_rr_after: got %0d want 0", dut.rr_ptr); end
        tests++;
        if (req_ready !== 4'b1111) begin fails++; $display("FAIL zero_slots_cleared: got %b want 1111", req_ready); end
        idle(3);
    endtask

    task automatic test_wrap();
        apply_reset();
        next_cycle();
        req_valid    = 4'b0100;
        req_index[2] = 7'd30;  req_data[2] = 32'h3000_0030;
        exp_q.push_back(mk_exp(cyc + 2, 2'b01, 7'd30, 32'h3000_0030, '0, '0));
        next_cycle();
        req_valid    = 4'b1001;
        req_index[3] = 7'd33;  req_data[3] = 32'h3300_0033;
        req_index[0] = 7'd34;  req_data[0] = 32'h3400_0034;
        next_cycle();
        req_valid = '0;
        exp_q.push_back(mk_exp(cyc + 1, 2'b11, 7'd33, 32'h3300_0033, 7'd34, 32'h3400_0034));
        @(negedge clock);
        tests++;
        if (dut.rr_ptr !== 2'd3) begin fails++; $display("FAIL wrap_rr_before: got %0d want 3", dut.rr_ptr); end
        next_cycle();
        @(negedge clock);
        tests++;
        if (dut.rr_ptr !== 2'd1) begin fails++; $display("FAIL wrap_rr_after: got %0d want 1", dut.rr_ptr); end
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req_valid    = 4'b0010;
            req_index[1] = 7'(40 + k);
            req_data[1]  = 32'hB000_0000 + 32'(k);
            exp_q.push_back(mk_exp(cyc + 2, 2'b01, 7'(40 + k), 32'hB000_0000 + 32'(k), '0, '0));
            @(negedge clock);
            tests++;
            if (req_ready[1] !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready k=%0d: got %b want 1", k, req_ready[1]);
            end
        end
        idle(4);
    endtask

    task automatic test_reset_mid_op();
        next_cycle();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_index[i] = 7'(50 + i);
            req_data[i]  = 32'h5000_0000 + 32'(i);
        end
        next_cycle();
        req_valid = '0;
        reset     = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (req_ready !== 4'b1111) begin fails++; $display("FAIL midrst_ready: got %b want 1111", req_ready); end
        tests++;
        if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL midrst_rr_ptr: got %0d want 0", dut.rr_ptr); end
        tests++;
        if (rd_en !== 2'b00) begin fails++; $display("FAIL midrst_rd_en: got %b want 00", rd_en); end
        idle(5);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_zero_index();
        test_wrap();
        test_back_to_back();
        test_reset_mid_op();
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clock);
        @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected writes still queued, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prf_int_wb_arbiter.md
# prf_int_wb_arbiter

Writeback arbiter for the integer physical register file. It collects result writes from NUM_REQ functional-unit requesters and buffers one result per requester. Each cycle it grants up to NUM_PORTS of those results in round-robin order and drives them, registered, onto the PRF write ports (rd_index/rd_data/rd_en). It sits between the execute-stage units (ALUs, mul/div, LSU) and the PRF write side.

## Interface
Parameters:
- NUM_REQ, 4, number of writeback requesters (must be ≥ NUM_PORTS).
- NUM_PORTS, `PRF_INT_WAYS, number of PRF write ports driven.
- IDX_W, `PRF_INT_INDEX_SIZE, physical register index width.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [NUM_REQ]  requester i offers a result.
- req_index  in  [NUM_REQ][IDX_W]  destination physical register.
- req_data  in  [NUM_REQ][32]  result value.
- req_ready  out  [NUM_REQ]  holding slot i can accept this cycle.
- rd_en  out  [NUM_PORTS]  registered PRF write enable per port.
- rd_index  out  [NUM_PORTS][IDX_W]  registered PRF write index.
- rd_data  out  [NUM_PORTS][32]  registered PRF write data.

## Operation
- State per requester: hold_valid, hold_index, hold_data. Global state: rr_ptr (range 0..NUM_REQ-1).
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Data is captured into slot i at the clock edge. req_valid must stay stable until the transfer.
- Readiness: req_ready[i] = !hold_valid[i] || grant[i]. grant depends only on registered state, so there is no combinational path from req_valid to req_ready.
- Grant selection (combinational):
  - Scan slots in order rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
  - The first NUM_PORTS slots with hold_valid=1 are granted.
  - The k-th granted slot is assigned to port k.
- Zero-index writes: a slot holding index 0 is granted and cleared like any other slot but consumes no port. Its port assignment is skipped, and no rd_en is ever produced for index 0.
- Outputs: rd_* register the port assignment. Ports with no assignment drive rd_en=0, rd_index=0, rd_data=0.
- Slot update:
  - A granted slot clears.
  - If it is simultaneously refilled, it loads the new request and stays valid.
  - A refill takes priority over the clear.
- rr_ptr update:
  - If any slot is granted, rr_ptr ← (index of the last granted slot + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
- Starvation bound: a valid slot is granted within ceil(NUM_REQ/NUM_PORTS) cycles.
- Duplicate rd_index values across slots are an upstream (rename) violation. They are not checked in RTL; the bench asserts against them.

## Timing
- Reset values: all hold_valid=0, rr_ptr=0, rd_en=0, rd_index=0, rd_data=0. req_ready is all ones in the first cycle after reset.
- Latency: handshake in cycle t → slot valid in t+1 → granted in t+1 → rd_en high in t+2. The PRF bypasses the value in t+2 and stores it at the end of t+2.
- Throughput: one result per requester per cycle when uncontended. Aggregate throughput is NUM_PORTS results per cycle.
- Full condition: a slot that is valid and not granted holds req_ready[i]=0. Its data stays unchanged until it is granted.
- Wrap-around: when rr_ptr = NUM_REQ-1, scanning continues through slot 0 upward.
- Reset asserted mid-operation: all held results are discarded, with no write to the PRF. Outputs are zero in the following cycle.

## Structure
- Shared package/header (micro_op.svh): `WB_INT_NUM_REQ and requester ID enum (WB_ALU0, WB_ALU1, WB_MDU, WB_LSU).
- Sub-module prf_int_wb_rr_pick: purely combinational.
  - Inputs: hold_valid, zero-index mask, rr_ptr.
  - Outputs: grant[NUM_REQ], per-port slot select and valid, next rr_ptr.
- Top level holds the slots, rr_ptr and output registers.

## Test plan
All scenarios use NUM_REQ=4, NUM_PORTS=2.
- Reset, then req_valid=0001 with index 5, data 0xDEAD → rd_en=01, rd_index[0]=5, rd_data[0]=0xDEAD two cycles later. rr_ptr=1.
- All 4 requesters valid every cycle from rr_ptr=0 (indices 10–13) → cycle t+1 grants slots 0,1 and t+2 grants slots 2,3. Slots granted each cycle see req_ready=1; slots not granted see req_ready=0.
- Requester 2 holds index 0 and requester 3 holds index 7, with rr_ptr=2 → slot 2 cleared, port 0 gets index 7, rd_en=01.
- rr_ptr=3 with slots 3 and 0 valid → port 0 gets slot 3, port 1 gets slot 0, rr_ptr becomes 1.
- Requester 1 streams back-to-back for 8 cycles with no contention → req_ready[1] stays 1 and 8 consecutive rd_en pulses appear.
- Fill all slots, then assert reset for 1 cycle → rd_en=0 with no stale writes afterwards, req_ready=1111, rr_ptr=0.
